// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: stage occupancy state and the default NOP payload.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter used for the stage's stall and flush debug counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step by one unless already pinned at all-ones
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a two-entry skid buffer, flush-to-NOP,
// hazard hold and saturating stall/flush debug counters.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_DEFAULT),
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             hold,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             in_fire;
    logic             out_fire;
    logic             stall_inc;
    logic             flush_inc;

    // State and entry registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Handshake outputs; reset also blocks any transfer in its own cycle
    always_comb begin
        in_ready  = (state_q != TWO) && !hold && !flush && !reset;
        out_valid = (state_q != EMPTY) && !hold && !flush && !reset;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        out_data  = out_valid ? main_q : NOP_VALUE;
        occupancy = state_q;
        stall_inc = (state_q != EMPTY) && !flush && (hold || !out_ready);
        flush_inc = flush && (state_q != EMPTY);
    end

    // Next state and entry contents; vacated entries return to NOP
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = NOP_VALUE;
                    end else begin
                        state_d = ONE;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end else begin
                        state_d = TWO;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register replacing the fixed-width, enable-only stage registers between IF/ID/EX/MEM/WB. Carries a WIDTH-bit bundle (instruction or control word) under a valid/ready handshake. A two-entry skid buffer decouples upstream and downstream stalls. Adds flush-to-NOP for branch squash, a hazard hold input, and saturating stall and flush counters for pipeline debug.

## Interface
- WIDTH, 32, payload width in bits.
- NOP_VALUE, 0 (WIDTH bits), payload driven on out_data when no valid entry; also the reset contents of both entries.
- CNT_W, 16, width of each performance counter.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage accepts the payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage presents a valid payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  payload to the next stage.
- hold  in  1  hazard stall; freezes both sides.
- flush  in  1  squash all held entries.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_count  out  CNT_W  saturating count of stalled cycles.
- flush_count  out  CNT_W  saturating count of effective flushes.

## Operation
- Storage: main entry and skid entry, each WIDTH bits. State is EMPTY, ONE (main valid) or TWO (main and skid valid).
- in_ready = (state != TWO) & !hold & !flush.
- out_valid = (state != EMPTY) & !hold & !flush.
- out_data = main when out_valid, else NOP_VALUE.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Transitions, applied only when flush = 0:
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE: in_fire & out_fire -> ONE, main <= in_data. in_fire only -> TWO, skid <= in_data. out_fire only -> EMPTY.
  - TWO: out_fire -> ONE, main <= skid. Otherwise stay in TWO.
- flush = 1: next state EMPTY and both entries <= NOP_VALUE. This overrides hold and any handshake, and no transfer occurs that cycle.
- hold = 1 with flush = 0: no transfer and state unchanged.
- Vacated entries are rewritten to NOP_VALUE, so a dead payload never leaks.
- occupancy mirrors state: EMPTY = 0, ONE = 1, TWO = 2.
- stall_count increments when (state != EMPTY) & !flush & (hold | !out_ready). It saturates at all-ones.
- flush_count increments when flush & (state != EMPTY). It saturates at all-ones.
- Reset values:
  - state EMPTY and both entries NOP_VALUE.
  - in_ready 1 when hold and flush are 0.
  - out_valid 0 and out_data NOP_VALUE.
  - occupancy 0 and both counters 0.
- Reset during operation discards all entries, with no output transfer that cycle.

## Timing
- Latency from in_fire to first out_valid: 1 cycle.
- Throughput is 1 per cycle when out_ready stays high.
- in_ready and out_valid are combinational only in hold and flush. Otherwise they are functions of the registered state.
- Full-rate case: a single out_ready deassertion is absorbed by the skid entry. in_ready drops only in the cycle after the second entry is captured.
- Payload order is strict FIFO, main before skid.
- in_valid may be withdrawn without penalty. Upstream is expected to hold in_data stable until in_fire.

## Structure
- Shared pipeline package:
  - state enum with EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2, sharing its encoding with occupancy;
  - the default NOP constant, 32'h0.
- Sub-module sat_counter, parameter W, with ports clk, reset, inc and count. It is instantiated twice.
- Existing stage registers are replaced by instances of this block, with WIDTH set to the bundle width.

## Test plan
- Reset, then in_valid = 1 with in_data 32'hE0811002 and out_ready = 1:
  - out_valid = 1 with that data one cycle later;
  - occupancy = 1.
- Stream 32'h1, 32'h2, 32'h3 back-to-back with out_ready low for one cycle on the second beat:
  - output order is 1, 2, 3 with no loss or duplication;
  - occupancy reaches 2 and in_ready = 0 for exactly one cycle.
- Fill to TWO, then assert flush for one cycle:
  - next cycle occupancy = 0, out_data = NOP_VALUE and flush_count = 1;
  - flush while EMPTY leaves flush_count unchanged.
- Hold high for 5 cycles while ONE:
  - in_ready = 0 and out_valid = 0 throughout;
  - stall_count = 5 and the payload is unchanged afterwards.
- CNT_W = 3 and out_ready low for 10 cycles while ONE: stall_count saturates at 7.
- Assert reset while TWO with out_ready = 1:
  - no out_fire that cycle;
  - the next cycle shows all outputs at their reset values.
